// File: rtl/sistema_pio_pkg.sv
// Shared constants for the SISTEMA PIO family: the 2-bit register window
// and the edge-type encoding. Also holds a counter-width helper.
package sistema_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // $clog2 of the stable-cycle count, never below one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sistema_sensor_in_pio_if.sv
// Avalon-MM slave bus bundle for the sensor input PIO.
interface sistema_sensor_in_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sistema_debounce.sv
// One-bit debouncer: a change on din is accepted into stable only after it
// has persisted for DEBOUNCE_CYCLES consecutive cycles.
module sistema_debounce
  import sistema_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // count while din disagrees with stable; any agreement restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (din == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= din;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sistema_sensor_in_pio.sv
// Sensor/switch input PIO: two-flop synchronizer, optional per-bit debounce
// (compiled in with SENSOR_PIO_DEBOUNCE_EN), edge detect, sticky
// write-1-to-clear edge capture and a maskable level interrupt.
module sistema_sensor_in_pio
  import sistema_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = EDGE_RISING,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  sistema_sensor_in_pio_if.slave bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  // elaboration-time parameter sanity
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (EDGE_TYPE < EDGE_RISING || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
    $error("EDGE_TYPE must be 0, 1 or 2");
  end

  logic [WIDTH-1:0] sync1, sync2, stable, prev;
  logic [WIDTH-1:0] pulse, clr;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [31:0]      rdata;
  logic             wr;

  // writedata bits above WIDTH carry nothing for this port
  logic unused_wd;
  assign unused_wd = ^bus.writedata;

  assign wr = bus.chipselect & ~bus.write_n;

  // two-flop synchronizer plus the one-cycle history used for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= stable;
    end
  end

`ifdef SENSOR_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    sistema_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .din    (sync2[i]),
      .stable (stable[i])
    );
  end
`else
  assign stable = sync2;
`endif

  // edge pulse selection; EDGE_TYPE is fixed at elaboration
  always_comb begin
    pulse = stable ^ prev;
    if (EDGE_TYPE == EDGE_RISING)       pulse = stable & ~prev;
    else if (EDGE_TYPE == EDGE_FALLING) pulse = ~stable & prev;
  end

  // write-1-to-clear mask for the edge capture register
  always_comb begin
    clr = '0;
    if (wr && bus.address == PIO_ADDR_EDGE) clr = bus.writedata[WIDTH-1:0];
  end

  // interrupt mask register
  always_ff @(posedge clk) begin
    if (reset)                                      irq_mask <= '0;
    else if (wr && bus.address == PIO_ADDR_IRQMASK) irq_mask <= bus.writedata[WIDTH-1:0];
  end

  // sticky edge capture; a new pulse beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) edge_cap <= '0;
    else       edge_cap <= (edge_cap & ~clr) | pulse;
  end

  assign irq = |(edge_cap & irq_mask);

  // zero-wait-state read mux, independent of chipselect
  always_comb begin
    rdata = '0;
    case (bus.address)
      PIO_ADDR_DATA:    rdata[WIDTH-1:0] = stable;
      PIO_ADDR_IRQMASK: rdata[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGE:    rdata[WIDTH-1:0] = edge_cap;
      default:          rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;

endmodule

// File: tb/tb_sistema_sensor_in_pio.sv
// Directed bench for sistema_sensor_in_pio. Two instances share clk, reset
// and in_port: dut0 captures rising edges, dut2 captures any edge.
// Debounce-specific scenarios run when SENSOR_PIO_DEBOUNCE_EN is defined.
module tb_sistema_sensor_in_pio;
  import sistema_pio_pkg::*;

  localparam int DB_CYC = 4;
`ifdef SENSOR_PIO_DEBOUNCE_EN
  localparam int LAT = 1 + DB_CYC;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in_port;
  logic       irq0, irq2;
  int         vectors = 0;
  int         errors  = 0;

  sistema_sensor_in_pio_if bus0 ();
  sistema_sensor_in_pio_if bus2 ();

  sistema_sensor_in_pio #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB_CYC)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port), .irq(irq0)
  );
  sistema_sensor_in_pio #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB_CYC)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int d, input logic [1:0] a, output logic [31:0] v);
    if (d == 0) begin bus0.address = a; #1 v = bus0.readdata; end
    else        begin bus2.address = a; #1 v = bus2.readdata; end
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v, input logic cs);
    if (d == 0) begin
      bus0.address = a; bus0.writedata = v; bus0.chipselect = cs; bus0.write_n = 1'b0;
    end else begin
      bus2.address = a; bus2.writedata = v; bus2.chipselect = cs; bus2.write_n = 1'b0;
    end
    tick();
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
  endtask

  task automatic quiesce;
    in_port = 8'h00;
    repeat (LAT + 3) tick();
    wr(0, PIO_ADDR_EDGE, 32'hFF, 1'b1);
    wr(2, PIO_ADDR_EDGE, 32'hFF, 1'b1);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    for (int a = 0; a < 4; a++) begin
      rd(0, 2'(a), v); vectors++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_read addr%0d: got %h want %h", a, v, 32'h0); end
    end
    vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq0: got %b want 0", irq0); end
    vectors++; if (irq2 !== 1'b0) begin errors++; $display("FAIL reset_irq2: got %b want 0", irq2); end
    wr(0, PIO_ADDR_DATA, 32'hFF, 1'b1);
    wr(0, PIO_ADDR_DIR, 32'hFF, 1'b1);
    rd(0, PIO_ADDR_DATA, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL data_write_ignored: got %h want %h", v, 32'h0); end
    in_port = 8'h5A;
    repeat (LAT + 2) tick();
    rd(0, PIO_ADDR_DATA, v); vectors++;
    if (v !== 32'h5A) begin errors++; $display("FAIL data_follows_input: got %h want %h", v, 32'h5A); end
    rd(0, PIO_ADDR_DIR, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL dir_zero: got %h want %h", v, 32'h0); end
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h5A) begin errors++; $display("FAIL edge_after_5a: got %h want %h", v, 32'h5A); end
    quiesce();
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL edge_cleared_all: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_irqmask;
    logic [31:0] v;
    wr(0, PIO_ADDR_IRQMASK, 32'hFF, 1'b0);
    rd(0, PIO_ADDR_IRQMASK, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL mask_needs_cs: got %h want %h", v, 32'h0); end
    wr(0, PIO_ADDR_IRQMASK, 32'hFFFF_FF81, 1'b1);
    rd(0, PIO_ADDR_IRQMASK, v); vectors++;
    if (v !== 32'h81) begin errors++; $display("FAIL mask_zero_extend: got %h want %h", v, 32'h81); end
    vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL mask_no_edge_irq: got %b want 0", irq0); end
  endtask

  task automatic test_rise(input int b);
    logic [31:0] v;
    logic [31:0] m;
    m = 32'h1 << b;
    wr(0, PIO_ADDR_IRQMASK, m, 1'b1);
    in_port[b] = 1'b1;
    tick();
    repeat (LAT - 1) tick();
    rd(0, PIO_ADDR_DATA, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL rise%0d_data_early: got %h want %h", b, v, 32'h0); end
    tick();
    rd(0, PIO_ADDR_DATA, v); vectors++;
    if (v !== m) begin errors++; $display("FAIL rise%0d_data: got %h want %h", b, v, m); end
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL rise%0d_edge_early: got %h want %h", b, v, 32'h0); end
    vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL rise%0d_irq_early: got %b want 0", b, irq0); end
    tick();
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== m) begin errors++; $display("FAIL rise%0d_edge: got %h want %h", b, v, m); end
    vectors++; if (irq0 !== 1'b1) begin errors++; $display("FAIL rise%0d_irq: got %b want 1", b, irq0); end
    wr(0, PIO_ADDR_EDGE, m, 1'b1);
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL rise%0d_w1c: got %h want %h", b, v, 32'h0); end
    vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL rise%0d_irq_clr: got %b want 0", b, irq0); end
    in_port[b] = 1'b0;
    repeat (LAT + 3) tick();
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL rise%0d_no_fall_capture: got %h want %h", b, v, 32'h0); end
    quiesce();
  endtask

  task automatic test_glitch;
    logic [31:0] v;
    in_port[2] = 1'b1;
    repeat (3) tick();
    in_port[2] = 1'b0;
    repeat (10) tick();
    rd(0, PIO_ADDR_DATA, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL glitch_data: got %h want %h", v, 32'h0); end
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL glitch_edge: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_set_wins;
    logic [31:0] v;
    in_port[3] = 1'b1;
    tick();
    repeat (LAT) tick();
    // the edge pulse is live now; clear lands on the same capture edge
    wr(0, PIO_ADDR_EDGE, 32'h08, 1'b1);
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h08) begin errors++; $display("FAIL set_wins_edge: got %h want %h", v, 32'h08); end
    wr(0, PIO_ADDR_EDGE, 32'h08, 1'b1);
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL set_wins_later_clr: got %h want %h", v, 32'h0); end
    quiesce();
  endtask

  task automatic test_any_edge;
    logic [31:0] v;
    in_port[1] = 1'b1;
    repeat (LAT + 2) tick();
    rd(2, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h02) begin errors++; $display("FAIL any_rise_edge: got %h want %h", v, 32'h02); end
    vectors++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_rise_irq_masked: got %b want 0", irq2); end
    wr(2, PIO_ADDR_EDGE, 32'h02, 1'b1);
    rd(2, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL any_clr: got %h want %h", v, 32'h0); end
    in_port[1] = 1'b0;
    repeat (LAT + 2) tick();
    rd(2, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h02) begin errors++; $display("FAIL any_fall_edge: got %h want %h", v, 32'h02); end
    vectors++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_fall_irq_masked: got %b want 0", irq2); end
    wr(2, PIO_ADDR_IRQMASK, 32'h02, 1'b1);
    vectors++; if (irq2 !== 1'b1) begin errors++; $display("FAIL any_irq_after_mask: got %b want 1", irq2); end
    quiesce();
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    in_port[4] = 1'b1;
    tick();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(0, PIO_ADDR_DATA, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h want %h", v, 32'h0); end
    rd(0, PIO_ADDR_IRQMASK, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL rstmid_mask: got %h want %h", v, 32'h0); end
    tick();
    repeat (LAT - 1) tick();
    rd(0, PIO_ADDR_DATA, v); vectors++;
    if (v !== 32'h0) begin errors++; $display("FAIL rstmid_data_early: got %h want %h", v, 32'h0); end
    tick();
    rd(0, PIO_ADDR_DATA, v); vectors++;
    if (v !== 32'h10) begin errors++; $display("FAIL rstmid_data_rise: got %h want %h", v, 32'h10); end
    tick();
    rd(0, PIO_ADDR_EDGE, v); vectors++;
    if (v !== 32'h10) begin errors++; $display("FAIL rstmid_edge: got %h want %h", v, 32'h10); end
    vectors++; if (irq0 !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b want 0", irq0); end
  endtask

  initial begin
    bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = 32'h0;
    bus2.address = 2'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = 32'h0;
    in_port = 8'h00;
    reset   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    test_reset();
    test_irqmask();
    test_rise(0);
`ifdef SENSOR_PIO_DEBOUNCE_EN
    test_glitch();
    test_rise(2);
`endif
    test_set_wins();
    test_any_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sistema_sensor_in_pio.md
# sistema_sensor_in_pio

Avalon-MM slave input port that samples up to WIDTH asynchronous sensor and switch lines into the system clock domain. Per bit it provides optional debouncing, edge detection, a sticky edge-capture register and a maskable interrupt to the Nios II processor. It is the input-direction counterpart of the SISTEMA output PIOs that drive the HEX displays, and uses the same 2-bit register window and zero-wait-state read path.

## Interface
- WIDTH, 8: number of input lines, 1..32.
- EDGE_TYPE, 0: edge captured; 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 50000: stable cycles required before a change is accepted (1 ms at 50 MHz), ≥1; used only with debounce compiled in.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero-extended above WIDTH.
- in_port  in  WIDTH  asynchronous sensor inputs.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0 DATA: RO, debounced level.
  - 1 DIR: RO, always 0.
  - 2 IRQMASK: RW.
  - 3 EDGECAPTURE: read; write 1 to clear a bit.
- Writes to addresses 0 and 1 are ignored. A write requires chipselect=1 and write_n=0.
- Synchronizer: two flops per bit, sync1 then sync2.
- Stable level `stable`:
  - With debounce: per-bit counter cnt.
    - sync2==stable: cnt<=0.
    - sync2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=sync2, cnt<=0.
    - Otherwise cnt<=cnt+1.
    - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
  - Without debounce: stable = sync2.
- prev <= stable every cycle.
- Edge pulse: rising = stable&~prev, falling = ~stable&prev, any = stable^prev, selected by EDGE_TYPE.
- EDGECAPTURE[i]:
  - Set on an edge pulse.
  - Cleared by a write to address 3 with writedata[i]=1.
  - Simultaneous set and clear: set wins, so no edge is lost.
- irq = |(EDGECAPTURE & IRQMASK), combinational from registers.
- readdata:
  - addr 0: stable.
  - addr 1: 0.
  - addr 2: IRQMASK.
  - addr 3: EDGECAPTURE.
  - Bits above WIDTH are 0. Output is independent of chipselect.
- Reset clears sync1, sync2, stable, prev, cnt, IRQMASK and EDGECAPTURE; irq=0 and readdata=0 for addresses 0..3.
- An input held high through reset produces a rising edge after release, which is captured if EDGE_TYPE permits. This is intended: software clears EDGECAPTURE at init.
- Reset asserted mid-debounce discards the partial count.

## Timing
- Latencies are measured from the clk edge k at which sync1 first samples the new in_port value.
- No debounce: sync2 and DATA change at k+1; EDGECAPTURE bit and irq at k+2.
- Debounce: stable and DATA change at k+1+DEBOUNCE_CYCLES; EDGECAPTURE and irq one cycle later.
- Register writes take effect at the clk edge of the write cycle; readback and irq reflect them the following cycle.
- Reads are zero-wait-state, with combinational readdata and read latency 0.
- in_port pulses shorter than one clk period may be missed. This is not a requirement.

## Configuration
- SENSOR_PIO_DEBOUNCE_EN defined: per-bit debounce counters instantiated; DEBOUNCE_CYCLES is honoured.
- SENSOR_PIO_DEBOUNCE_EN undefined: no counters; stable = sync2; DEBOUNCE_CYCLES is ignored. Register map and irq behaviour are identical.

## Structure
- Shared package sistema_pio_pkg:
  - Address constants PIO_ADDR_DATA=0, PIO_ADDR_DIR=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGE=3.
  - Edge-type constants EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2.
- Sub-module sistema_debounce: one bit wide, counter width $clog2(DEBOUNCE_CYCLES), generated WIDTH times under the macro.
- Synchronizer, edge logic and registers stay in the top module.

## Test plan
- Reset, then read addresses 0..3 with in_port=0 → all read 0 and irq=0. Write 0xFF to address 0 → DATA still follows in_port.
- No debounce, EDGE_TYPE=0, IRQMASK=0x01:
  - in_port[0] rises at edge k → DATA bit0=1 at k+1, EDGECAPTURE=0x01 and irq=1 at k+2.
  - Write 0x01 to address 3 → EDGECAPTURE=0 and irq=0 next cycle.
- Debounce, DEBOUNCE_CYCLES=4:
  - in_port[2] high for 3 cycles, then low → DATA and EDGECAPTURE unchanged.
  - Held high for 10 cycles → DATA=0x04 at k+5 and EDGECAPTURE=0x04 at k+6.
- Write-1-to-clear of bit 3 in the same cycle as a new bit-3 edge pulse → EDGECAPTURE bit3 remains 1.
- EDGE_TYPE=2, IRQMASK=0, toggle in_port[1] → EDGECAPTURE bit1 set on both edges and irq stays 0. Then write IRQMASK=0x02 → irq=1 next cycle.
- Assert reset while a debounce count is at 2 → after release, cnt restarts from 0 and stable=0.
